// File: rtl/skein_mode_sequencer_if.sv
// Control/status bundle between the UBI block controller and skein_mode_sequencer.
// The abort_i signal exists only when SKEIN_SEQ_ABORT_EN is defined.
interface skein_mode_sequencer_if #(
    parameter int WCW = 4,
    parameter int RCW = 7,
    parameter int SKW = 5
);
    logic           start_i;
    logic           en_i;
`ifdef SKEIN_SEQ_ABORT_EN
    logic           abort_i;
`endif
    logic [1:0]     mode_o;
    logic [WCW-1:0] word_cnt_o;
    logic [RCW-1:0] round_cnt_o;
    logic [SKW-1:0] subkey_idx_o;
    logic           last_word_o;
    logic           busy_o;
    logic           done_o;

`ifdef SKEIN_SEQ_ABORT_EN
    modport master (
        output start_i, en_i, abort_i,
        input  mode_o, word_cnt_o, round_cnt_o, subkey_idx_o, last_word_o, busy_o, done_o
    );
    modport slave (
        input  start_i, en_i, abort_i,
        output mode_o, word_cnt_o, round_cnt_o, subkey_idx_o, last_word_o, busy_o, done_o
    );
`else
    modport master (
        output start_i, en_i,
        input  mode_o, word_cnt_o, round_cnt_o, subkey_idx_o, last_word_o, busy_o, done_o
    );
    modport slave (
        input  start_i, en_i,
        output mode_o, word_cnt_o, round_cnt_o, subkey_idx_o, last_word_o, busy_o, done_o
    );
`endif
endinterface

// File: rtl/skein_mode_sequencer.sv
// Threefish/Skein block sequencer: walks GEN/ADD/MIX phases and owns word, round and subkey counters.
// Optional abort input enabled by defining SKEIN_SEQ_ABORT_EN.
module skein_mode_sequencer #(
    parameter int NUM_WORDS         = 16,
    parameter int NUM_ROUNDS        = 80,
    parameter int ROUNDS_PER_SUBKEY = 4,
    parameter int MIX_CYCLES        = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    skein_mode_sequencer_if.slave bus
);
    localparam int WMAX        = (NUM_WORDS > MIX_CYCLES) ? NUM_WORDS : MIX_CYCLES;
    localparam int WCW         = $clog2(WMAX);
    localparam int RCW         = $clog2(NUM_ROUNDS + 1);
    localparam int NUM_SUBKEYS = (ROUNDS_PER_SUBKEY > 0) ? NUM_ROUNDS / ROUNDS_PER_SUBKEY : 0;
    localparam int SKW         = $clog2(NUM_SUBKEYS + 1);

    generate
        if (!(NUM_WORDS == 4 || NUM_WORDS == 8 || NUM_WORDS == 16)) begin : g_bad_words
            $error("skein_mode_sequencer: NUM_WORDS must be 4, 8 or 16");
        end
        if (ROUNDS_PER_SUBKEY < 1 || NUM_ROUNDS < 1 ||
            (NUM_ROUNDS % ((ROUNDS_PER_SUBKEY > 0) ? ROUNDS_PER_SUBKEY : 1)) != 0) begin : g_bad_rounds
            $error("skein_mode_sequencer: NUM_ROUNDS must be a positive multiple of ROUNDS_PER_SUBKEY");
        end
        if (MIX_CYCLES < 1) begin : g_bad_mix
            $error("skein_mode_sequencer: MIX_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        GEN  = 2'b00,
        ADD  = 2'b01,
        MIX  = 2'b10,
        IDLE = 2'b11
    } mode_e;

    mode_e          mode_q, mode_d;
    logic [WCW-1:0] word_q, word_d;
    logic [RCW-1:0] round_q, round_d;
    logic [SKW-1:0] sk_q, sk_d;
    logic           busy_q, done_q, done_d;
    logic           last_word;
    logic           abort_req;
    logic [RCW-1:0] round_inc;
    logic [RCW-1:0] subkey_boundary;

`ifdef SKEIN_SEQ_ABORT_EN
    assign abort_req = bus.abort_i;
`else
    assign abort_req = 1'b0;
`endif

    assign round_inc       = round_q + RCW'(1);
    // Rounds covered by the subkeys added so far; reaching it means the next subkey is due.
    assign subkey_boundary = RCW'(int'(sk_q) * ROUNDS_PER_SUBKEY);

    always_comb begin
        mode_d    = mode_q;
        word_d    = word_q;
        round_d   = round_q;
        sk_d      = sk_q;
        done_d    = 1'b0;
        last_word = 1'b0;

        case (mode_q)
            GEN, ADD: last_word = (word_q == WCW'(NUM_WORDS - 1));
            MIX:      last_word = (word_q == WCW'(MIX_CYCLES - 1));
            default:  last_word = 1'b0;
        endcase

        if (mode_q == IDLE) begin
            if (bus.start_i && !abort_req) begin
                mode_d  = GEN;
                word_d  = '0;
                round_d = '0;
                sk_d    = '0;
            end
        end else if (abort_req) begin
            mode_d  = IDLE;
            word_d  = '0;
            round_d = '0;
            sk_d    = '0;
        end else if (bus.en_i) begin
            case (mode_q)
                GEN: begin
                    if (last_word) begin
                        mode_d = ADD;
                        word_d = '0;
                    end else begin
                        word_d = word_q + WCW'(1);
                    end
                end
                ADD: begin
                    if (!last_word) begin
                        word_d = word_q + WCW'(1);
                    end else if (sk_q == SKW'(NUM_SUBKEYS)) begin
                        mode_d = IDLE;
                        done_d = 1'b1;
                    end else begin
                        mode_d = MIX;
                        word_d = '0;
                        sk_d   = sk_q + SKW'(1);
                    end
                end
                MIX: begin
                    if (last_word) begin
                        word_d  = '0;
                        round_d = round_inc;
                        if (round_inc == subkey_boundary) mode_d = GEN;
                    end else begin
                        word_d = word_q + WCW'(1);
                    end
                end
                default: mode_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q  <= IDLE;
            word_q  <= '0;
            round_q <= '0;
            sk_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            word_q  <= word_d;
            round_q <= round_d;
            sk_q    <= sk_d;
            busy_q  <= (mode_d != IDLE);
            done_q  <= done_d;
        end
    end

    assign bus.mode_o       = mode_q;
    assign bus.word_cnt_o   = word_q;
    assign bus.round_cnt_o  = round_q;
    assign bus.subkey_idx_o = sk_q;
    assign bus.last_word_o  = last_word;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
endmodule

// File: tb/tb_skein_mode_sequencer.sv
// Directed bench for skein_mode_sequencer: default 1024-bit geometry plus a small 4-word geometry.
module tb_skein_mode_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    skein_mode_sequencer_if #(.WCW(4), .RCW(7), .SKW(5)) bus_a ();
    skein_mode_sequencer_if #(.WCW(2), .RCW(4), .SKW(2)) bus_b ();

    skein_mode_sequencer dut_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus_a.slave)
    );

    skein_mode_sequencer #(
        .NUM_WORDS        (4),
        .NUM_ROUNDS       (8),
        .ROUNDS_PER_SUBKEY(4),
        .MIX_CYCLES       (2)
    ) dut_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus_b.slave)
    );

    int         em [40];
    int         ew [40];
    logic [17:0] ref_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] pack_a();
        return {bus_a.mode_o, bus_a.word_cnt_o, bus_a.round_cnt_o, bus_a.subkey_idx_o};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, n, idx, stalls, terr, lastc, donec;

        rst_n         = 1'b0;
        bus_a.start_i = 1'b0;
        bus_a.en_i    = 1'b0;
        bus_b.start_i = 1'b0;
        bus_b.en_i    = 1'b0;
`ifdef SKEIN_SEQ_ABORT_EN
        bus_a.abort_i = 1'b0;
        bus_b.abort_i = 1'b0;
`endif
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_mode",  bus_a.mode_o, 3);
        chk("rst_word",  bus_a.word_cnt_o, 0);
        chk("rst_round", bus_a.round_cnt_o, 0);
        chk("rst_sk",    bus_a.subkey_idx_o, 0);
        chk("rst_busy",  bus_a.busy_o, 0);
        chk("rst_done",  bus_a.done_o, 0);
        chk("rst_last",  bus_a.last_word_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Small geometry: expected trace GEN4 ADD4 MIX8 GEN4 ADD4 MIX8 GEN4 ADD4
        k = 0;
        for (int p = 0; p < 3; p++) begin
            for (int w = 0; w < 4; w++) begin em[k] = 0; ew[k] = w; k++; end
            for (int w = 0; w < 4; w++) begin em[k] = 1; ew[k] = w; k++; end
            if (p < 2) for (int c = 0; c < 8; c++) begin em[k] = 2; ew[k] = c % 2; k++; end
        end
        bus_b.en_i    = 1'b1;
        bus_b.start_i = 1'b1;
        @(negedge clk);
        bus_b.start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            chk("b_mode", bus_b.mode_o, em[i]);
            chk("b_word", bus_b.word_cnt_o, ew[i]);
            chk("b_last", bus_b.last_word_o, (em[i] == 2) ? (ew[i] == 1) : (ew[i] == 3));
            @(negedge clk);
        end
        chk("b_end_mode",  bus_b.mode_o, 3);
        chk("b_end_busy",  bus_b.busy_o, 0);
        chk("b_end_done",  bus_b.done_o, 1);
        chk("b_end_round", bus_b.round_cnt_o, 8);
        chk("b_end_sk",    bus_b.subkey_idx_o, 2);
        @(negedge clk);
        chk("b_done_clear", bus_b.done_o, 0);
        chk("b_hold_round", bus_b.round_cnt_o, 8);

        // Start accepted with en low, then frozen until en rises
        bus_b.en_i    = 1'b0;
        bus_b.start_i = 1'b1;
        @(negedge clk);
        bus_b.start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("b_stall_mode",  bus_b.mode_o, 0);
            chk("b_stall_word",  bus_b.word_cnt_o, 0);
            chk("b_stall_round", bus_b.round_cnt_o, 0);
            @(negedge clk);
        end
        bus_b.en_i = 1'b1;
        n = 0;
        while (bus_b.busy_o && n < 200) begin n++; @(negedge clk); end
        chk("b_len_after_stall", n, 40);
        chk("b_done_after_stall", bus_b.done_o, 1);
        @(negedge clk);

        // start held high: back-to-back blocks, restart in the done cycle
        bus_b.start_i = 1'b1;
        @(negedge clk);
        n = 0;
        while (bus_b.busy_o && n < 200) begin n++; @(negedge clk); end
        chk("b_b2b_len1", n, 40);
        chk("b_b2b_done_mode", bus_b.mode_o, 3);
        chk("b_b2b_done", bus_b.done_o, 1);
        @(negedge clk);
        chk("b_b2b_restart_mode", bus_b.mode_o, 0);
        chk("b_b2b_restart_done", bus_b.done_o, 0);
        chk("b_b2b_restart_round", bus_b.round_cnt_o, 0);
        chk("b_b2b_restart_sk", bus_b.subkey_idx_o, 0);
        n = 0;
        while (bus_b.busy_o && n < 200) begin
            n++;
            if (n == 20) bus_b.start_i = 1'b0;
            @(negedge clk);
        end
        chk("b_b2b_len2", n, 40);
        chk("b_b2b_done2", bus_b.done_o, 1);
        @(negedge clk);
        chk("b_b2b_stays_idle", bus_b.mode_o, 3);

        // Default geometry, unstalled reference run
        bus_a.en_i    = 1'b1;
        bus_a.start_i = 1'b1;
        @(negedge clk);
        bus_a.start_i = 1'b0;
        chk("a_start_mode", bus_a.mode_o, 0);
        n = 0; lastc = 0; donec = 0;
        while (bus_a.busy_o && n < 5000) begin
            ref_q.push_back(pack_a());
            if (bus_a.last_word_o) lastc++;
            if (bus_a.done_o) donec++;
            n++;
            @(negedge clk);
        end
        chk("a_len", n, 1312);
        chk("a_last_count", lastc, 122);
        chk("a_done_while_busy", donec, 0);
        chk("a_done", bus_a.done_o, 1);
        chk("a_round", bus_a.round_cnt_o, 80);
        chk("a_sk", bus_a.subkey_idx_o, 20);
        @(negedge clk);
        chk("a_done_clear", bus_a.done_o, 0);

        // Default geometry with pseudo-random stalls
        bus_a.start_i = 1'b1;
        @(negedge clk);
        bus_a.start_i = 1'b0;
        n = 0; idx = 0; stalls = 0; terr = 0;
        while (bus_a.busy_o && n < 5000) begin
            if (idx >= ref_q.size() || pack_a() != ref_q[idx]) terr++;
            bus_a.en_i = 1'($urandom_range(0, 1));
            if (bus_a.en_i) idx++; else stalls++;
            n++;
            @(negedge clk);
        end
        bus_a.en_i = 1'b1;
        chk("a_stall_trace_err", terr, 0);
        chk("a_stall_len", n, 1312 + stalls);
        chk("a_stall_steps", idx, 1312);
        chk("a_stall_done", bus_a.done_o, 1);
        @(negedge clk);

`ifdef SKEIN_SEQ_ABORT_EN
        // Abort at round 37, then a full block
        bus_a.start_i = 1'b1;
        @(negedge clk);
        bus_a.start_i = 1'b0;
        n = 0;
        while (bus_a.round_cnt_o != 7'd37 && n < 5000) begin n++; @(negedge clk); end
        chk("ab_reach_37", bus_a.round_cnt_o, 37);
        bus_a.abort_i = 1'b1;
        bus_a.en_i    = 1'b0;
        @(negedge clk);
        bus_a.abort_i = 1'b0;
        bus_a.en_i    = 1'b1;
        chk("ab_mode",  bus_a.mode_o, 3);
        chk("ab_word",  bus_a.word_cnt_o, 0);
        chk("ab_round", bus_a.round_cnt_o, 0);
        chk("ab_sk",    bus_a.subkey_idx_o, 0);
        chk("ab_done",  bus_a.done_o, 0);
        bus_a.abort_i = 1'b1;
        bus_a.start_i = 1'b1;
        @(negedge clk);
        bus_a.abort_i = 1'b0;
        chk("ab_wins_mode", bus_a.mode_o, 3);
        @(negedge clk);
        bus_a.start_i = 1'b0;
        n = 0;
        while (bus_a.busy_o && n < 5000) begin n++; @(negedge clk); end
        chk("ab_full_len", n, 1312);
        chk("ab_full_done", bus_a.done_o, 1);
        @(negedge clk);
`endif

        // Asynchronous reset mid-MIX
        bus_a.start_i = 1'b1;
        @(negedge clk);
        bus_a.start_i = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_mix_mode", bus_a.mode_o, 2);
        rst_n = 1'b0;
        #1;
        chk("arst_mode",  bus_a.mode_o, 3);
        chk("arst_word",  bus_a.word_cnt_o, 0);
        chk("arst_round", bus_a.round_cnt_o, 0);
        chk("arst_sk",    bus_a.subkey_idx_o, 0);
        chk("arst_busy",  bus_a.busy_o, 0);
        chk("arst_done",  bus_a.done_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_after_mode", bus_a.mode_o, 3);
        chk("arst_after_done", bus_a.done_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
